// File: rtl/etm_div_pkg.sv
// Shared definitions for the ETM sequential approximate divider.
//   - etm_div_state_e : FSM state encoding (idle / run / done)
//   - Def*            : default width constants
//   - clog2()         : ceiling log2, used to size the iteration counter
package etm_div_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } etm_div_state_e;

   localparam int unsigned DefWidth      = 16;
   localparam int unsigned DefDWidth     = 8;
   localparam int unsigned DefApproxBits = 4;

   // Ceiling log2; clog2(value) bits hold 0..value-1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/etm_div_step.sv
// One combinational restoring-division step.
//   rem_i     : partial remainder entering the step (always < divisor)
//   bit_i     : next dividend bit shifted in
//   divisor_i : divisor
//   rem_o     : partial remainder leaving the step
//   q_bit_o   : quotient bit produced by this step
module etm_div_step
   import etm_div_pkg::*;
#(
   parameter int unsigned DWIDTH = DefDWidth
) (
   input  logic [DWIDTH-1:0] rem_i,
   input  logic              bit_i,
   input  logic [DWIDTH-1:0] divisor_i,
   output logic [DWIDTH-1:0] rem_o,
   output logic              q_bit_o
);

   // Shifted remainder needs one extra bit; the result is again < divisor.
   logic [DWIDTH:0] shifted;
   logic [DWIDTH:0] dvs_ext;

   always_comb begin
      shifted = {rem_i, bit_i};
      dvs_ext = {1'b0, divisor_i};
      q_bit_o = (shifted >= dvs_ext);
      if (q_bit_o) begin
         rem_o = DWIDTH'(shifted - dvs_ext);
      end else begin
         rem_o = shifted[DWIDTH-1:0];
      end
   end

endmodule

// File: rtl/etm_div_seq.sv
// Sequential approximate (ETM-style) divider.
// The upper WIDTH-APPROX_BITS quotient bits are computed exactly, one restoring
// step per cycle; the low APPROX_BITS are filled with all-ones when any residue
// remains (partial remainder or discarded dividend bits), else zeros.
// Optional macro ETM_DIV_RUNTIME_APPROX_EN adds port approx_en (sampled at
// accept): 0 selects an exact WIDTH-step divide, 1 the approximate one.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   dividend, divisor    : unsigned operands
//   approx_en            : runtime approximation enable (macro builds only)
//   out_valid / out_ready: result handshake, result held until taken
//   quotient, remainder  : result; remainder is the last partial remainder
//   div_by_zero          : divisor was zero (quotient all-ones)
module etm_div_seq
   import etm_div_pkg::*;
#(
   parameter int unsigned WIDTH       = DefWidth,
   parameter int unsigned DWIDTH      = DefDWidth,
   parameter int unsigned APPROX_BITS = DefApproxBits
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  dividend,
   input  logic [DWIDTH-1:0] divisor,
`ifdef ETM_DIV_RUNTIME_APPROX_EN
   input  logic              approx_en,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  quotient,
   output logic [DWIDTH-1:0] remainder,
   output logic              div_by_zero
);

   localparam int unsigned CntW = clog2(WIDTH + 1);
   localparam logic [CntW-1:0] NApprox = CntW'(WIDTH - APPROX_BITS);
   localparam logic [CntW-1:0] NExact  = CntW'(WIDTH);
   localparam logic [WIDTH-1:0] LowMask = (WIDTH'(1) << APPROX_BITS) - WIDTH'(1);

   logic use_approx;
`ifdef ETM_DIV_RUNTIME_APPROX_EN
   assign use_approx = approx_en;
`else
   assign use_approx = 1'b1;
`endif

   etm_div_state_e state_q, state_d;

   logic [WIDTH-1:0]  dvd_q, dvd_d;       // dividend, shifted out MSB first
   logic [WIDTH-1:0]  quo_q, quo_d;       // exact quotient bits, shifted in LSB first
   logic [DWIDTH-1:0] rem_q, rem_d;
   logic [DWIDTH-1:0] dvs_q, dvs_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              low_nz_q, low_nz_d; // discarded dividend bits were non-zero
   logic              approx_q, approx_d;
   logic [WIDTH-1:0]  quotient_q, quotient_d;
   logic [DWIDTH-1:0] remainder_q, remainder_d;
   logic              dbz_q, dbz_d;

   logic [DWIDTH-1:0] step_rem;
   logic              step_q;
   logic [WIDTH-1:0]  quo_next;
   logic              fill;

   etm_div_step #(
      .DWIDTH (DWIDTH)
   ) u_step (
      .rem_i     (rem_q),
      .bit_i     (dvd_q[WIDTH-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .q_bit_o   (step_q)
   );

   // State register and datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         dvd_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         low_nz_q    <= 1'b0;
         approx_q    <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         low_nz_q    <= low_nz_d;
         approx_q    <= approx_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = (divisor == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (cnt_q == CntW'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state.
   always_comb begin
      dvd_d       = dvd_q;
      quo_d       = quo_q;
      rem_d       = rem_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      low_nz_d    = low_nz_q;
      approx_d    = approx_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      quo_next    = {quo_q[WIDTH-2:0], step_q};
      // With APPROX_BITS=0 LowMask is zero, so the fill never reaches the result.
      fill        = approx_q & ((step_rem != '0) | low_nz_q);

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               dvd_d    = dividend;
               quo_d    = '0;
               rem_d    = '0;
               dvs_d    = divisor;
               approx_d = use_approx;
               low_nz_d = (dividend & LowMask) != '0;
               cnt_d    = use_approx ? NApprox : NExact;
               if (divisor == '0) begin
                  quotient_d  = '1;
                  remainder_d = '0;
                  dbz_d       = 1'b1;
               end else begin
                  dbz_d = 1'b0;
               end
            end
         end
         StRun: begin
            dvd_d = dvd_q << 1;
            quo_d = quo_next;
            rem_d = step_rem;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               if (approx_q) begin
                  quotient_d = (quo_next << APPROX_BITS) | (fill ? LowMask : '0);
               end else begin
                  quotient_d = quo_next;
               end
               remainder_d = step_rem;
            end
         end
         default: ;
      endcase
   end

   // Outputs.
   always_comb begin
      in_ready    = (state_q == StIdle);
      out_valid   = (state_q == StDone);
      quotient    = quotient_q;
      remainder   = remainder_q;
      div_by_zero = dbz_q;
   end

endmodule

// File: tb/tb_etm_div_seq.sv
module tb_etm_div_seq;

   localparam int unsigned W  = 16;
   localparam int unsigned DW = 8;
   localparam int unsigned AB = 4;
`ifdef ETM_DIV_RUNTIME_APPROX_EN
   localparam bit RtApprox = 1'b1;
`else
   localparam bit RtApprox = 1'b0;
`endif

   typedef struct {
      logic [W-1:0]  quo;
      logic [DW-1:0] rem;
      logic          dbz;
      int            lat;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  dividend;
   logic [DW-1:0] divisor;
   logic          approx_en;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  quotient;
   logic [DW-1:0] remainder;
   logic          div_by_zero;

   int   n_checks;
   int   n_fail;
   exp_t sb[$];

   etm_div_seq #(
      .WIDTH       (W),
      .DWIDTH      (DW),
      .APPROX_BITS (AB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef ETM_DIV_RUNTIME_APPROX_EN
      .approx_en   (approx_en),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact divide of the kept upper bits, ETM fill of the low bits.
   function automatic exp_t model(input logic [W-1:0] a, input logic [DW-1:0] b, input logic ax);
      exp_t        e;
      int unsigned n, upper, qu, r, mask;
      logic        fill;
      if (b == 0) begin
         e.quo = '1; e.rem = '0; e.dbz = 1'b1; e.lat = 1;
         return e;
      end
      n     = ax ? (W - AB) : W;
      upper = 32'(a) >> (W - n);
      qu    = upper / 32'(b);
      r     = upper % 32'(b);
      mask  = (32'd1 << AB) - 1;
      fill  = (r != 0) || ((32'(a) & mask) != 0);
      e.quo = ax ? W'((qu << AB) | (fill ? mask : 0)) : W'(qu);
      e.rem = DW'(r);
      e.dbz = 1'b0;
      e.lat = n + 1;
      return e;
   endfunction

   task automatic start_op(input logic [W-1:0] a, input logic [DW-1:0] b, input logic ax);
      sb.push_back(model(a, b, RtApprox ? ax : 1'b1));
      @(negedge clk);
      dividend  = a;
      divisor   = b;
      approx_en = ax;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Counts edges from the accept edge (inclusive) until out_valid shows.
   task automatic wait_result(output int edges);
      edges = 1;
      while (!out_valid && edges < 200) begin
         @(posedge clk);
         edges++;
         #1;
      end
   endtask

   task automatic compare_result(input int edges);
      exp_t e;
      if (sb.size() == 0) begin
         check_eq("sb_empty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      check_eq("out_valid", 32'(out_valid), 32'd1);
      check_eq("quotient", 32'(quotient), 32'(e.quo));
      check_eq("remainder", 32'(remainder), 32'(e.rem));
      check_eq("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      check_eq("latency", 32'(edges), 32'(e.lat));
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [DW-1:0] b, input logic ax);
      int edges;
      out_ready = 1'b1;
      start_op(a, b, ax);
      wait_result(edges);
      compare_result(edges);
      @(posedge clk);
      #1;
      check_eq("idle_after_take", {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   initial begin
      int          edges;
      logic [W-1:0] q_hold;
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      approx_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_quotient", 32'(quotient), 32'd0);
      check_eq("rst_remainder", 32'(remainder), 32'd0);
      check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors.
      do_op(16'd100, 8'd7, 1'b1);
      check_eq("q_100_7_const", 32'(quotient), 32'h000F);
      do_op(16'h0070, 8'd7, 1'b1);
      check_eq("q_70_7_const", 32'(quotient), 32'h0010);
      do_op(16'hFFFF, 8'd1, 1'b1);
      do_op(16'h1234, 8'd0, 1'b1);
      do_op(16'd50, 8'd5, 1'b1);
      do_op(16'h0000, 8'd3, 1'b1);
      do_op(16'hFFFF, 8'hFF, 1'b1);
      if (RtApprox) begin
         do_op(16'd100, 8'd7, 1'b0);
         check_eq("q_100_7_exact", 32'(quotient), 32'd14);
         do_op(16'hFFFF, 8'hFF, 1'b0);
      end

      // Random operands.
      for (int i = 0; i < 20; i++) begin
         do_op(W'($urandom), (i % 7 == 0) ? DW'(0) : DW'($urandom_range(1, 255)),
               1'($urandom));
      end

      // Backpressure: result held, new operands ignored.
      out_ready = 1'b0;
      start_op(16'd100, 8'd7, 1'b1);
      wait_result(edges);
      q_hold = quotient;
      @(negedge clk);
      dividend = 16'h5555;
      divisor  = 8'd3;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_eq("bp_out_valid", 32'(out_valid), 32'd1);
         check_eq("bp_in_ready", 32'(in_ready), 32'd0);
         check_eq("bp_quotient_stable", 32'(quotient), 32'(q_hold));
      end
      @(negedge clk);
      in_valid = 1'b0;
      compare_result(edges);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);

      // Reset mid-run aborts the operation.
      start_op(16'hABCD, 8'd9, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb.delete();
      check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_quotient", 32'(quotient), 32'd0);
      check_eq("mid_rst_remainder", 32'(remainder), 32'd0);
      check_eq("mid_rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (out_valid) check_eq("stale_result", 32'(out_valid), 32'd0);
      end
      do_op(16'd50, 8'd5, 1'b1);
      check_eq("q_50_5_const", 32'(quotient), 32'h000F);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
